// File: rtl/iob_fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer, regfile write port, level/full.
// Optional sticky overflow flag is built only when IOB_FIFO_WR_OVERFLOW_EN is defined.
module iob_fifo_wr_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cke_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  output logic [ADDR_W:0]   w_level_o,
  input  logic [ADDR_W:0]   r_gray_ptr_i,
  output logic [ADDR_W:0]   w_gray_ptr_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              overflow_o
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** ADDR_W);

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_pub_gray;
  logic [PTR_W-1:0]  r_w_gray;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic [PTR_W-1:0]  w_rbin;
  logic [PTR_W-1:0]  w_level;
  logic              w_full;
  logic              w_accept;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  assign w_rbin[ADDR_W] = r_gray_ptr_i[ADDR_W];
  generate
    for (genvar gi = ADDR_W - 1; gi >= 0; gi--) begin : g_gray2bin
      assign w_rbin[gi] = w_rbin[gi+1] ^ r_gray_ptr_i[gi];
    end
  endgenerate

  assign w_level  = r_wptr - w_rbin;
  assign w_full   = (w_level == DEPTH);
  assign w_accept = cke_i & w_en_i & ~w_full;

  // The pointer is published two edges after the accept: one stage to form the
  // Gray code from the settled pointer, one to register the output.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wptr     <= '0;
      r_pub_gray <= '0;
      r_w_gray   <= '0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
    end else if (cke_i) begin
      r_pub_gray <= r_wptr ^ (r_wptr >> 1);
      r_w_gray   <= r_pub_gray;
      if (w_accept) begin
        r_rf_addr <= r_wptr[ADDR_W-1:0];
        r_rf_data <= w_data_i;
        r_wptr    <= r_wptr + 1'b1;
      end
    end
  end

`ifdef IOB_FIFO_WR_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_overflow <= 1'b0;
    end else if (cke_i & w_en_i & w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
`else
  assign overflow_o = 1'b0;
`endif

  assign w_full_o     = w_full;
  assign w_level_o    = w_level;
  assign w_gray_ptr_o = r_w_gray;
  assign rf_addr_o    = r_rf_addr;
  assign rf_data_o    = r_rf_data;

endmodule

// File: tb/tb_iob_fifo_wr_ctrl.sv
// Directed table-driven bench for iob_fifo_wr_ctrl (ADDR_W=3, DATA_W=21), plus a wrap sequence.
module tb_iob_fifo_wr_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 21;
`ifdef IOB_FIFO_WR_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cke;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic [ADDR_W:0]   w_level;
  logic [ADDR_W:0]   r_gray;
  logic [ADDR_W:0]   w_gray;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iob_fifo_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cke_i       (cke),
    .w_en_i      (w_en),
    .w_data_i    (w_data),
    .w_full_o    (w_full),
    .w_level_o   (w_level),
    .r_gray_ptr_i(r_gray),
    .w_gray_ptr_o(w_gray),
    .rf_addr_o   (rf_addr),
    .rf_data_o   (rf_data),
    .overflow_o  (overflow)
  );

  typedef struct {
    logic              rst_n;
    logic              cke;
    logic              wen;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   rg;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [ADDR_W:0]   e_lvl;
    logic              e_full;
    logic [ADDR_W:0]   e_gray;
    logic              e_ovf;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];

  function automatic logic [ADDR_W:0] g(input int b);
    logic [ADDR_W:0] x;
    x = ADDR_W'(b);
    x = 4'(b & 15);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic we, input int d, input int rg,
                              input int ea, input int ed, input int el, input logic ef, input int eg,
                              input logic eo);
    vec_t v;
    v.rst_n = r; v.cke = c; v.wen = we; v.data = DATA_W'(d); v.rg = 4'(rg);
    v.e_addr = 3'(ea); v.e_data = DATA_W'(ed); v.e_lvl = 4'(el); v.e_full = ef;
    v.e_gray = 4'(eg); v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic we, input logic [DATA_W-1:0] d,
                       input logic [ADDR_W:0] rg);
    rst_n = r; cke = c; w_en = we; w_data = d; r_gray = rg;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, '0, '0);

    // Reset, then a single push and its two-edge publish latency.
    vec[0]  = mk(0, 1, 1, 'h5,     0, 0, 0,       0, 0, 0,   0);
    vec[1]  = mk(1, 1, 1, 'h1ABCD, 0, 0, 'h1ABCD, 1, 0, 0,   0);
    vec[2]  = mk(1, 1, 0, 0,       0, 0, 'h1ABCD, 1, 0, 0,   0);
    vec[3]  = mk(1, 1, 0, 0,       0, 0, 'h1ABCD, 1, 0, 1,   0);
    vec[4]  = mk(0, 1, 0, 0,       0, 0, 0,       0, 0, 0,   0);
    // Fill to full with the reader parked at zero.
    for (int i = 0; i < 8; i++)
      vec[5+i] = mk(1, 1, 1, 'h100 + i, 0, i, 'h100 + i, i + 1, (i == 7), (i >= 1) ? int'(g(i - 1)) : 0, 0);
    vec[13] = mk(1, 1, 1, 'h1FF,   0, 7, 'h107,   8, 1, 'h4, OVF);
    vec[14] = mk(1, 1, 0, 0,       0, 7, 'h107,   8, 1, 'hC, OVF);
    // Reader advances in the same cycle as a push while full.
    vec[15] = mk(1, 1, 1, 'h2AA,   1, 0, 'h2AA,   8, 1, 'hC, OVF);
    vec[16] = mk(1, 1, 0, 0,       2, 0, 'h2AA,   6, 0, 'hC, OVF);
    vec[17] = mk(1, 0, 1, 'h3FF,   2, 0, 'h2AA,   6, 0, 'hC, OVF);
    vec[18] = mk(1, 1, 1, 'h333,   2, 1, 'h333,   7, 0, 'hD, OVF);
    vec[19] = mk(1, 1, 1, 'h444,   2, 2, 'h444,   8, 1, 'hD, OVF);
    // Reset mid-burst drops the pending publishes.
    vec[20] = mk(0, 1, 1, 'h555,   0, 0, 0,       0, 0, 0,   0);
    vec[21] = mk(1, 1, 0, 0,       0, 0, 0,       0, 0, 0,   0);
    vec[22] = mk(1, 1, 0, 0,       0, 0, 0,       0, 0, 0,   0);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].rst_n, vec[i].cke, vec[i].wen, vec[i].data, vec[i].rg);
      edge_sample();
      $display("vec %0d: rst_n=%0b cke=%0b wen=%0b data=0x%0h rg=0x%0h -> addr=%0d data=0x%0h lvl=%0d full=%0b gray=0x%0h ovf=%0b",
               i, rst_n, cke, w_en, w_data, r_gray, rf_addr, rf_data, w_level, w_full, w_gray, overflow);
      chk("rf_addr",  i, 32'(rf_addr),  32'(vec[i].e_addr));
      chk("rf_data",  i, 32'(rf_data),  32'(vec[i].e_data));
      chk("w_level",  i, 32'(w_level),  32'(vec[i].e_lvl));
      chk("w_full",   i, 32'(w_full),   32'(vec[i].e_full));
      chk("w_gray",   i, 32'(w_gray),   32'(vec[i].e_gray));
      chk("overflow", i, 32'(overflow), 32'(vec[i].e_ovf));
    end

    // 16 pushes with the reader consuming each word immediately: pointer wraps, never full.
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b1, 1'b1, DATA_W'(k), g(k - 1));
      edge_sample();
      $display("wrap push %0d: addr=%0d lvl=%0d full=%0b gray=0x%0h", k, rf_addr, w_level, w_full, w_gray);
      chk("wrap_addr", 100 + k, 32'(rf_addr), 32'((k - 1) & 7));
      chk("wrap_data", 100 + k, 32'(rf_data), 32'(k));
      chk("wrap_lvl",  100 + k, 32'(w_level), 32'd1);
      chk("wrap_full", 100 + k, 32'(w_full),  32'd0);
      chk("wrap_gray", 100 + k, 32'(w_gray),  (k >= 2) ? 32'(g(k - 2)) : 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, '0, g(16));
    edge_sample();
    $display("wrap idle 1: gray=0x%0h lvl=%0d", w_gray, w_level);
    chk("wrap_gray15", 117, 32'(w_gray), 32'h8);
    chk("wrap_lvl0",   117, 32'(w_level), 32'd0);
    edge_sample();
    $display("wrap idle 2: gray=0x%0h", w_gray);
    chk("wrap_gray16", 118, 32'(w_gray), 32'h0);
    chk("wrap_ovf",    118, 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
